mem_access_unit: RTL and testbench

Memory stage of the RISC-V pipeline, directly downstream of the ALU/ALUdec execute stage. It takes the ALU result, which is either a load/store effective address or an arithmetic result. For loads and stores it runs a request/response transaction with data memory, generating byte enables and store-lane replication. Load data is aligned and sign- or zero-extended, and every register-writing result is presented to writeback as a one-cycle pulse.

---
 rtl/mem_access_unit_pkg.sv | 73 +++++++
 rtl/mem_access_unit_load_align.sv | 38 +++
 rtl/mem_access_unit.sv | 117 +++++++++++
 tb/tb_mem_access_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared opcode/funct encodings and store-lane helpers for the memory stage.
package mem_access_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPC_W = 7;
  localparam int unsigned FNC_W = 3;
  localparam int unsigned REG_W = 5;
  localparam int unsigned WE_W = 4;

  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;

  localparam logic [FNC_W-1:0] FNC_LB  = 3'b000;
  localparam logic [FNC_W-1:0] FNC_LH  = 3'b001;
  localparam logic [FNC_W-1:0] FNC_LW  = 3'b010;
  localparam logic [FNC_W-1:0] FNC_LBU = 3'b100;
  localparam logic [FNC_W-1:0] FNC_LHU = 3'b101;
  localparam logic [FNC_W-1:0] FNC_SB  = 3'b000;
  localparam logic [FNC_W-1:0] FNC_SH  = 3'b001;
  localparam logic [FNC_W-1:0] FNC_SW  = 3'b010;

  // Legal funct and natural alignment for the given access.
  function automatic logic access_ok(input logic is_store,
                                     input logic [FNC_W-1:0] funct,
                                     input logic [1:0] lane);
    logic ok;
    ok = 1'b0;
    if (is_store) begin
      case (funct)
        FNC_SB:  ok = 1'b1;
        FNC_SH:  ok = ~lane[0];
        FNC_SW:  ok = (lane == 2'b00);
        default: ok = 1'b0;
      endcase
    end else begin
      case (funct)
        FNC_LB, FNC_LBU: ok = 1'b1;
        FNC_LH, FNC_LHU: ok = ~lane[0];
        FNC_LW:          ok = (lane == 2'b00);
        default:         ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  function automatic logic [WE_W-1:0] store_we(input logic [FNC_W-1:0] funct,
                                               input logic [1:0] lane);
    logic [WE_W-1:0] we;
    we = '0;
    case (funct)
      FNC_SB:  we = 4'b0001 << lane;
      FNC_SH:  we = lane[1] ? 4'b1100 : 4'b0011;
      FNC_SW:  we = 4'b1111;
      default: we = '0;
    endcase
    return we;
  endfunction

  // Replicate the stored unit across every lane it could occupy.
  function automatic logic [XLEN-1:0] store_wdata(input logic [FNC_W-1:0] funct,
                                                  input logic [XLEN-1:0] sd);
    logic [XLEN-1:0] wd;
    wd = sd;
    case (funct)
      FNC_SB:  wd = {4{sd[7:0]}};
      FNC_SH:  wd = {2{sd[15:0]}};
      default: wd = sd;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load data lane selection with sign/zero extension.
module load_align
  import mem_access_unit_pkg::*;
(
  input  logic [FNC_W-1:0] funct,
  input  logic [1:0]       lane,
  input  logic [XLEN-1:0]  rdata,
  output logic [XLEN-1:0]  data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[7:0];
    case (lane)
      2'd0: byte_v = rdata[7:0];
      2'd1: byte_v = rdata[15:8];
      2'd2: byte_v = rdata[23:16];
      2'd3: byte_v = rdata[31:24];
      default: byte_v = rdata[7:0];
    endcase
  end

  assign half_v = lane[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = rdata;
    case (funct)
      FNC_LB:  data = {{24{byte_v[7]}}, byte_v};
      FNC_LBU: data = {24'd0, byte_v};
      FNC_LH:  data = {{16{half_v[15]}}, half_v};
      FNC_LHU: data = {16'd0, half_v};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Pipeline memory stage: load/store request/response sequencing and writeback pulse.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic             Clock,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPC_W-1:0] opcode,
  input  logic [FNC_W-1:0] funct,
  input  logic [XLEN-1:0]  alu_out,
  input  logic [XLEN-1:0]  store_data,
  input  logic [REG_W-1:0] rd,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [XLEN-1:0]  mem_addr,
  output logic [WE_W-1:0]  mem_we,
  output logic [XLEN-1:0]  mem_wdata,
  input  logic             mem_rsp_valid,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic             wb_valid,
  output logic [REG_W-1:0] wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic             fault,
  output logic [XLEN-1:0]  fault_addr
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t           state;
  logic             is_load_q;
  logic [FNC_W-1:0] funct_q;
  logic [1:0]       lane_q;
  logic [REG_W-1:0] rd_q;
  logic [XLEN-1:0]  load_data;
  logic             is_load;
  logic             is_store;

  assign in_ready = (state == ST_IDLE) && !Reset;
  assign is_load  = (opcode == OPC_LOAD);
  assign is_store = (opcode == OPC_STORE);

  load_align u_load_align (
    .funct (funct_q),
    .lane  (lane_q),
    .rdata (mem_rdata),
    .data  (load_data)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state         <= ST_IDLE;
      is_load_q     <= 1'b0;
      funct_q       <= '0;
      lane_q        <= '0;
      rd_q          <= '0;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      mem_we        <= '0;
      mem_wdata     <= '0;
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      fault         <= 1'b0;
      fault_addr    <= '0;
    end else begin
      wb_valid <= 1'b0;
      fault    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (is_load || is_store) begin
              if (!access_ok(is_store, funct, alu_out[1:0])) begin
                fault      <= 1'b1;
                fault_addr <= alu_out;
              end else begin
                mem_req_valid <= 1'b1;
                mem_addr      <= {alu_out[XLEN-1:2], 2'b00};
                mem_we        <= is_store ? store_we(funct, alu_out[1:0]) : WE_W'(0);
                mem_wdata     <= store_wdata(funct, store_data);
                is_load_q     <= is_load;
                funct_q       <= funct;
                lane_q        <= alu_out[1:0];
                rd_q          <= rd;
                state         <= ST_REQ;
              end
            end else if (opcode != OPC_BRANCH && rd != REG_W'(0)) begin
              wb_valid <= 1'b1;
              wb_rd    <= rd;
              wb_data  <= alu_out;
            end
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= is_load_q ? ST_WAIT : ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (mem_rsp_valid) begin
            wb_valid <= (rd_q != REG_W'(0));
            wb_rd    <= rd_q;
            wb_data  <= load_data;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit and the standalone load_align.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct;
  logic [31:0] alu_out;
  logic [31:0] store_data;
  logic [4:0]  rd;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        fault;
  logic [31:0] fault_addr;

  logic [2:0]  la_funct;
  logic [1:0]  la_lane;
  logic [31:0] la_rdata;
  logic [31:0] la_data;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] OPC_ARI = 7'b0110011;

  mem_access_unit dut (
    .Clock         (clk),
    .Reset         (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .opcode        (opcode),
    .funct         (funct),
    .alu_out       (alu_out),
    .store_data    (store_data),
    .rd            (rd),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .fault         (fault),
    .fault_addr    (fault_addr)
  );

  load_align u_la (
    .funct (la_funct),
    .lane  (la_lane),
    .rdata (la_rdata),
    .data  (la_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] fn,
                       input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] r);
    in_valid   = 1'b1;
    opcode     = op;
    funct      = fn;
    alu_out    = addr;
    store_data = sd;
    rd         = r;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; opcode = '0; funct = '0; alu_out = '0; store_data = '0; rd = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
    la_funct = '0; la_lane = '0; la_rdata = '0;

    // Reset state
    tick(); tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_fault_addr", fault_addr, 32'd0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // LB at 0x1003 with a one-cycle request handshake
    issue(OPC_LOAD, FNC_LB, 32'h0000_1003, 32'h0, 5'd7);
    tick();
    in_valid = 1'b0;
    check("lb_req_valid", 32'(mem_req_valid), 32'd1);
    check("lb_addr", mem_addr, 32'h0000_1000);
    check("lb_we", 32'(mem_we), 32'd0);
    check("lb_in_ready", 32'(in_ready), 32'd0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("lb_wait_req", 32'(mem_req_valid), 32'd0);
    check("lb_wait_ready", 32'(in_ready), 32'd0);
    mem_rsp_valid = 1'b1; mem_rdata = 32'h80FF_1234;
    tick();
    mem_rsp_valid = 1'b0;
    check("lb_wb_valid", 32'(wb_valid), 32'd1);
    check("lb_wb_rd", 32'(wb_rd), 32'd7);
    check("lb_wb_data", wb_data, 32'hFFFF_FF80);
    check("lb_idle", 32'(in_ready), 32'd1);
    tick();
    check("lb_wb_pulse", 32'(wb_valid), 32'd0);

    // SH at 0x2002
    issue(OPC_STORE, FNC_SH, 32'h0000_2002, 32'hDEAD_BEEF, 5'd0);
    tick();
    in_valid = 1'b0;
    check("sh_req_valid", 32'(mem_req_valid), 32'd1);
    check("sh_addr", mem_addr, 32'h0000_2000);
    check("sh_we", 32'(mem_we), 32'hC);
    check("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("sh_done_req", 32'(mem_req_valid), 32'd0);
    check("sh_in_ready", 32'(in_ready), 32'd1);
    check("sh_no_wb", 32'(wb_valid), 32'd0);

    // SB at 0x11 replicates the byte into every lane
    issue(OPC_STORE, FNC_SB, 32'h0000_0011, 32'h1234_56AB, 5'd0);
    tick();
    in_valid = 1'b0;
    check("sb_we", 32'(mem_we), 32'h2);
    check("sb_wdata", mem_wdata, 32'hABAB_ABAB);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("sb_in_ready", 32'(in_ready), 32'd1);

    // Misaligned LW
    issue(OPC_LOAD, FNC_LW, 32'h0000_3001, 32'h0, 5'd4);
    tick();
    in_valid = 1'b0;
    check("lw_fault", 32'(fault), 32'd1);
    check("lw_fault_addr", fault_addr, 32'h0000_3001);
    check("lw_no_req", 32'(mem_req_valid), 32'd0);
    check("lw_in_ready", 32'(in_ready), 32'd1);
    check("lw_no_wb", 32'(wb_valid), 32'd0);
    tick();
    check("lw_fault_pulse", 32'(fault), 32'd0);

    // Illegal store funct
    issue(OPC_STORE, 3'b011, 32'h0000_0040, 32'h0, 5'd0);
    tick();
    in_valid = 1'b0;
    check("st_illegal_fault", 32'(fault), 32'd1);
    check("st_illegal_no_req", 32'(mem_req_valid), 32'd0);

    // Back-to-back ALU results, second has rd=0, then a branch
    issue(OPC_ARI, 3'b000, 32'h0000_1234, 32'h0, 5'd5);
    tick();
    check("ari_wb_valid", 32'(wb_valid), 32'd1);
    check("ari_wb_rd", 32'(wb_rd), 32'd5);
    check("ari_wb_data", wb_data, 32'h0000_1234);
    issue(OPC_ARI, 3'b000, 32'h0000_5555, 32'h0, 5'd0);
    tick();
    check("ari_rd0_no_wb", 32'(wb_valid), 32'd0);
    issue(OPC_BRANCH, 3'b000, 32'h0000_7777, 32'h0, 5'd3);
    tick();
    in_valid = 1'b0;
    check("branch_no_wb", 32'(wb_valid), 32'd0);

    // LHU at 0x4002 with a stalled request and a delayed response
    issue(OPC_LOAD, FNC_LHU, 32'h0000_4002, 32'h0, 5'd12);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("lhu_stall_req", 32'(mem_req_valid), 32'd1);
      check("lhu_stall_addr", mem_addr, 32'h0000_4000);
      check("lhu_stall_we", 32'(mem_we), 32'd0);
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    tick();
    check("lhu_wait_no_wb", 32'(wb_valid), 32'd0);
    check("lhu_wait_ready", 32'(in_ready), 32'd0);
    mem_rsp_valid = 1'b1; mem_rdata = 32'hABCD_0000;
    tick();
    mem_rsp_valid = 1'b0;
    check("lhu_wb_valid", 32'(wb_valid), 32'd1);
    check("lhu_wb_rd", 32'(wb_rd), 32'd12);
    check("lhu_wb_data", wb_data, 32'h0000_ABCD);

    // Reset while waiting for a load response
    issue(OPC_LOAD, FNC_LW, 32'h0000_5000, 32'h0, 5'd9);
    tick();
    in_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    check("rstw_req", 32'(mem_req_valid), 32'd0);
    check("rstw_wb", 32'(wb_valid), 32'd0);
    check("rstw_ready_low", 32'(in_ready), 32'd0);
    rst = 1'b0;
    mem_rsp_valid = 1'b1; mem_rdata = 32'h1111_2222;
    #1;
    check("rstw_in_ready", 32'(in_ready), 32'd1);
    tick();
    mem_rsp_valid = 1'b0;
    check("rstw_late_rsp", 32'(wb_valid), 32'd0);
    check("rstw_fault", 32'(fault), 32'd0);

    // Standalone load_align vectors
    la_funct = FNC_LH;  la_lane = 2'd2; la_rdata = 32'h8001_7F00; #1;
    check("la_lh_hi", la_data, 32'hFFFF_8001);
    la_funct = FNC_LBU; la_lane = 2'd1; la_rdata = 32'h0000_F100; #1;
    check("la_lbu", la_data, 32'h0000_00F1);
    la_funct = FNC_LB;  la_lane = 2'd0; la_rdata = 32'h0000_007F; #1;
    check("la_lb_pos", la_data, 32'h0000_007F);
    la_funct = FNC_LH;  la_lane = 2'd0; la_rdata = 32'h1234_9ABC; #1;
    check("la_lh_lo", la_data, 32'hFFFF_9ABC);
    la_funct = FNC_LW;  la_lane = 2'd0; la_rdata = 32'hCAFE_F00D; #1;
    check("la_lw", la_data, 32'hCAFE_F00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
